// File: rtl/vga_pkg.sv
// vga_pkg: shared raster constants and decode helper for the VGA timing generator.
//   COORD_W           width of the xx/yy coordinate bus
//   VGA_*             640x480 @ 60 Hz timing (pixels / lines)
//   raster_flags_t    per-pixel flag bundle (sync levels, active, strobes)
//   raster_decode()   maps a coordinate to its raster flags
package vga_pkg;

    localparam int unsigned COORD_W = 10;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic hsync_n;
        logic vsync_n;
        logic active;
        logic frame_start;
        logic animate;
    } raster_flags_t;

    // Flags of the last pixel of a frame, which is where reset parks the raster.
    localparam raster_flags_t FLAGS_RESET = '{
        hsync_n:     1'b1,
        vsync_n:     1'b1,
        active:      1'b0,
        frame_start: 1'b0,
        animate:     1'b0
    };

    function automatic raster_flags_t raster_decode(
        input coord_t x,
        input coord_t y,
        input coord_t h_act,
        input coord_t hs_first,
        input coord_t hs_last,
        input coord_t v_act,
        input coord_t vs_first,
        input coord_t vs_last
    );
        raster_flags_t f;
        f.hsync_n     = !((x >= hs_first) && (x <= hs_last));
        f.vsync_n     = !((y >= vs_first) && (y <= vs_last));
        f.active      = (x < h_act) && (y < v_act);
        f.frame_start = (x == '0) && (y == '0);
        f.animate     = (x == '0) && (y == v_act);
        return f;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: DEPTH-stage shift register with a configurable reset value.
//   clk_i   clock
//   rst_ni  asynchronous active-low reset, loads every stage with RST_VAL
//   d_i     input bit
//   q_o     d_i delayed by DEPTH cycles (combinational pass-through when DEPTH=0)
module sync_delay_line #(
    parameter int unsigned DEPTH   = 1,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = ^{clk_i, rst_ni};
        assign q_o = d_i;
    end else begin : g_shift
        logic [DEPTH-1:0] sr_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sr_q <= {DEPTH{RST_VAL}};
            end else begin
                sr_q[0] <= d_i;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    sr_q[i] <= sr_q[i-1];
                end
            end
        end

        assign q_o = sr_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing from the pixel clock.
//   Pclk, rst_n                     pixel clock, async active-low reset
//   xx, yy                          current pixel coordinate (counter registers)
//   aactive, hsync, vsync           decode of xx/yy, same-cycle aligned (syncs active-low)
//   frame_start, animate            one-cycle strobes at (0,0) and (0,V_ACTIVE)
//   frame_cnt                       frames started since reset, 16-bit wrapping
//   hsync_d, vsync_d, aactive_d     hsync/vsync/aactive delayed SYNC_DELAY cycles
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
    parameter int unsigned H_FP       = VGA_H_FP,
    parameter int unsigned H_SYNC     = VGA_H_SYNC,
    parameter int unsigned H_BP       = VGA_H_BP,
    parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
    parameter int unsigned V_FP       = VGA_V_FP,
    parameter int unsigned V_SYNC     = VGA_V_SYNC,
    parameter int unsigned V_BP       = VGA_V_BP,
    parameter int unsigned SYNC_DELAY = 1
) (
    input  logic               Pclk,
    input  logic               rst_n,
    output logic [COORD_W-1:0] xx,
    output logic [COORD_W-1:0] yy,
    output logic               aactive,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start,
    output logic               animate,
    output logic [15:0]        frame_cnt,
    output logic               hsync_d,
    output logic               vsync_d,
    output logic               aactive_d
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
    localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    coord_t        h_q, h_d;
    coord_t        v_q, v_d;
    raster_flags_t flags_q, flags_d;
    logic [15:0]   frame_cnt_q;

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    // Flags are decoded from the next coordinate so that, once registered,
    // they describe the same pixel the counters hold.
    always_comb begin
        flags_d = raster_decode(h_d, v_d, H_ACT_C, HS_FIRST, HS_LAST,
                                V_ACT_C, VS_FIRST, VS_LAST);
    end

    // Reset parks the raster on the last pixel, so the first edge lands on (0,0).
    always_ff @(posedge Pclk or negedge rst_n) begin
        if (!rst_n) begin
            h_q         <= H_LAST;
            v_q         <= V_LAST;
            flags_q     <= FLAGS_RESET;
            frame_cnt_q <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            flags_q <= flags_d;
            if (flags_d.frame_start) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    assign xx          = h_q;
    assign yy          = v_q;
    assign aactive     = flags_q.active;
    assign hsync       = flags_q.hsync_n;
    assign vsync       = flags_q.vsync_n;
    assign frame_start = flags_q.frame_start;
    assign animate     = flags_q.animate;
    assign frame_cnt   = frame_cnt_q;

    sync_delay_line #(.DEPTH(SYNC_DELAY), .RST_VAL(1'b1)) u_hsync_dly (
        .clk_i  (Pclk),
        .rst_ni (rst_n),
        .d_i    (flags_q.hsync_n),
        .q_o    (hsync_d)
    );

    sync_delay_line #(.DEPTH(SYNC_DELAY), .RST_VAL(1'b1)) u_vsync_dly (
        .clk_i  (Pclk),
        .rst_ni (rst_n),
        .d_i    (flags_q.vsync_n),
        .q_o    (vsync_d)
    );

    sync_delay_line #(.DEPTH(SYNC_DELAY), .RST_VAL(1'b0)) u_active_dly (
        .clk_i  (Pclk),
        .rst_ni (rst_n),
        .d_i    (flags_q.active),
        .q_o    (aactive_d)
    );

endmodule
